// File: rtl/me_search_ctrl.sv
// me_search_ctrl
// Sequencer for the full-search motion estimation datapath. A start pulse launches a raster
// scan (row by row, X fastest) of every candidate displacement in the MV_MIN..MV_MAX window.
// Each candidate is handed to the SAD datapath with a one-cycle request. The result is awaited
// and compared against the running minimum.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   search request, honoured only in IDLE or DONE
//   sad_req    out  one-cycle pulse: evaluate cand_x/cand_y
//   cand_x     out  candidate X displacement, 4-bit two's complement
//   cand_y     out  candidate Y displacement, 4-bit two's complement
//   sad_done   in   datapath result strobe, only looked at in WAIT
//   sad_val    in   SAD for the last requested candidate
//   BestDist   out  minimum SAD found so far / final result
//   motionX    out  X displacement of BestDist
//   motionY    out  Y displacement of BestDist
//   completed  out  search finished and results stable (masked by start)
//   busy       out  high in ISSUE, WAIT and UPDATE
module me_search_ctrl #(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int MV_MIN     = -8,
  parameter int MV_MAX     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       sad_req,
  output logic [3:0] cand_x,
  output logic [3:0] cand_y,
  input  logic       sad_done,
  input  logic [7:0] sad_val,
  output logic [7:0] BestDist,
  output logic [3:0] motionX,
  output logic [3:0] motionY,
  output logic       completed,
  output logic       busy
);

  localparam logic [3:0] MvMin = 4'(MV_MIN);
  localparam logic [3:0] MvMax = 4'(MV_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StUpdate,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [3:0] cand_x_q, cand_x_d;
  logic [3:0] cand_y_q, cand_y_d;
  logic [7:0] sad_q, sad_d;
  logic [7:0] best_q, best_d;
  logic [3:0] mvx_q, mvx_d;
  logic [3:0] mvy_q, mvy_d;
  logic       first_q, first_d;
  logic       done_q, done_d;

  logic       last_cand;
  logic       zero_hit;
  logic       take;
  logic       search_end;

  // Decision terms used in UPDATE. The sampled SAD is compared, not the live sad_val bus.
  always_comb begin
    last_cand  = (cand_x_q == MvMax) && (cand_y_q == MvMax);
    zero_hit   = EARLY_EXIT && (sad_q == 8'd0);
    // Strict compare keeps the raster-first candidate on ties. first_q forces the very first
    // result in even when it equals the 8'hFF start value.
    take       = first_q || (sad_q < best_q);
    search_end = zero_hit || last_cand;
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // No timeout: the datapath is trusted to answer eventually.
        if (sad_done) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        state_d = search_end ? StDone : StIssue;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sad_req   = (state_q == StIssue);
    busy      = (state_q == StIssue) || (state_q == StWait) || (state_q == StUpdate);
    // Masked so a restart pulse never coincides with a stale completion indication.
    completed = done_q && !start;
    cand_x    = cand_x_q;
    cand_y    = cand_y_q;
    BestDist  = best_q;
    motionX   = mvx_q;
    motionY   = mvy_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    sad_d    = sad_q;
    best_d   = best_q;
    mvx_d    = mvx_q;
    mvy_d    = mvy_q;
    first_d  = first_q;
    done_d   = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          done_d   = 1'b0;
          best_d   = 8'hFF;
          first_d  = 1'b1;
          cand_x_d = MvMin;
          cand_y_d = MvMin;
        end
      end
      StWait: begin
        if (sad_done) begin
          sad_d = sad_val;
        end
      end
      StUpdate: begin
        if (take) begin
          best_d = sad_q;
          mvx_d  = cand_x_q;
          mvy_d  = cand_y_q;
        end
        first_d = 1'b0;
        if (search_end) begin
          done_d = 1'b1;
        end else if (cand_x_q == MvMax) begin
          // End of row: back to the left edge, one row down.
          cand_x_d = MvMin;
          cand_y_d = cand_y_q + 4'd1;
        end else begin
          cand_x_d = cand_x_q + 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cand_x_q <= 4'h8;
      cand_y_q <= 4'h8;
      sad_q    <= 8'd0;
      best_q   <= 8'hFF;
      mvx_q    <= 4'h0;
      mvy_q    <= 4'h0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      sad_q    <= sad_d;
      best_q   <= best_d;
      mvx_q    <= mvx_d;
      mvy_q    <= mvy_d;
      first_q  <= first_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: two instances (EARLY_EXIT=0 and EARLY_EXIT=1) run side by side,
// each served by its own 2-cycle-latency SAD responder.
module tb_me_search_ctrl;

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       sreq, sdone, cmp, bsy;
  logic [1:0][3:0]  cx, cy, mx, my;
  logic [1:0][7:0]  sval, bd;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  bit mon_en = 1'b0;
  int req_cnt[2];
  int exp_best[2], exp_mx[2], exp_my[2], exp_cnt[2];
  int dcnt[2];

  me_search_ctrl #(.EARLY_EXIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .sad_req(sreq[0]), .cand_x(cx[0]),
    .cand_y(cy[0]), .sad_done(sdone[0]), .sad_val(sval[0]), .BestDist(bd[0]),
    .motionX(mx[0]), .motionY(my[0]), .completed(cmp[0]), .busy(bsy[0])
  );

  me_search_ctrl #(.EARLY_EXIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .sad_req(sreq[1]), .cand_x(cx[1]),
    .cand_y(cy[1]), .sad_done(sdone[1]), .sad_val(sval[1]), .BestDist(bd[1]),
    .motionX(mx[1]), .motionY(my[1]), .completed(cmp[1]), .busy(bsy[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // SAD patterns: 0 = |dx-3|+|dy+2|, 1 = all 8'hFF, 2 = 5 at (-1,0) and (2,0), else 9.
  function automatic int sad_fn(input int m, input int x, input int y);
    int ax, ay;
    ax = x - 3;
    ay = y + 2;
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    case (m)
      0:       return ax + ay;
      1:       return 255;
      default: return ((x == -1 || x == 2) && y == 0) ? 5 : 9;
    endcase
  endfunction

  // Reference search: raster scan, strict-less minimum, optional stop on zero.
  task automatic model(input int m, input bit ee, output int best, output int mvx,
                       output int mvy, output int cnt);
    best = 255;
    mvx  = 0;
    mvy  = 0;
    cnt  = 0;
    for (int i = 0; i < 256; i++) begin
      int x, y, s;
      x   = -8 + i % 16;
      y   = -8 + i / 16;
      s   = sad_fn(m, x, y);
      cnt = i + 1;
      if (i == 0 || s < best) begin
        best = s;
        mvx  = x & 15;
        mvy  = y & 15;
      end
      if (ee && s == 0) break;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Datapath responders: sad_done two cycles after each sad_req cycle.
  initial begin
    sdone   = '0;
    sval    = '0;
    dcnt[0] = 0;
    dcnt[1] = 0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        sdone[k] = 1'b0;
        if (dcnt[k] > 0) begin
          dcnt[k]--;
          if (dcnt[k] == 0) sdone[k] = 1'b1;
        end
        if (sreq[k]) begin
          int x, y;
          x       = $signed(cx[k]);
          y       = $signed(cy[k]);
          dcnt[k] = 2;
          sval[k] = 8'(sad_fn(mode, x, y));
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled at the falling edge.
  task automatic monitor();
    if (!mon_en) return;
    for (int k = 0; k < 2; k++) begin
      if (start && !bsy[k] && !reset) req_cnt[k] = 0;
      if (sreq[k]) begin
        chk($sformatf("dut%0d cand_x req%0d", k, req_cnt[k]), cx[k], (req_cnt[k] % 16 + 8) % 16);
        chk($sformatf("dut%0d cand_y req%0d", k, req_cnt[k]), cy[k], (req_cnt[k] / 16 + 8) % 16);
        chk($sformatf("dut%0d busy_on_req", k), bsy[k], 1);
        req_cnt[k]++;
      end
      if (start || bsy[k]) chk($sformatf("dut%0d completed_masked", k), cmp[k], 0);
      if (cmp[k]) begin
        chk($sformatf("dut%0d BestDist_done", k), bd[k], exp_best[k]);
        chk($sformatf("dut%0d motionX_done", k), mx[k], exp_mx[k]);
        chk($sformatf("dut%0d motionY_done", k), my[k], exp_my[k]);
        chk($sformatf("dut%0d busy_done", k), bsy[k], 0);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic load_model(input int m);
    mode = m;
    model(m, 1'b0, exp_best[0], exp_mx[0], exp_my[0], exp_cnt[0]);
    model(m, 1'b1, exp_best[1], exp_mx[1], exp_my[1], exp_cnt[1]);
  endtask

  task automatic wait_and_check(input bit busy_pulses);
    for (int i = 0; i < 3000; i++) begin
      if (cmp[0] && cmp[1]) break;
      if (busy_pulses) start = (i % 7 == 3) && bsy[0] && bsy[1];
      step();
      start = 1'b0;
    end
    chk("completion_timeout", int'(cmp[0] && cmp[1]), 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d request_count", k), req_cnt[k], exp_cnt[k]);
      chk($sformatf("dut%0d BestDist", k), bd[k], exp_best[k]);
      chk($sformatf("dut%0d motionX", k), mx[k], exp_mx[k]);
      chk($sformatf("dut%0d motionY", k), my[k], exp_my[k]);
    end
  endtask

  task automatic run(input int m, input bit busy_pulses);
    load_model(m);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start0", bsy[0], 1);
    chk("busy_after_start1", bsy[1], 1);
    wait_and_check(busy_pulses);
  endtask

  initial begin
    int b, x, y, c;
    reset      = 1'b1;
    start      = 1'b0;
    req_cnt[0] = 0;
    req_cnt[1] = 0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d rst sad_req", k), sreq[k], 0);
      chk($sformatf("dut%0d rst cand_x", k), cx[k], 8);
      chk($sformatf("dut%0d rst cand_y", k), cy[k], 8);
      chk($sformatf("dut%0d rst busy", k), bsy[k], 0);
      chk($sformatf("dut%0d rst BestDist", k), bd[k], 255);
      chk($sformatf("dut%0d rst motionX", k), mx[k], 0);
      chk($sformatf("dut%0d rst motionY", k), my[k], 0);
      chk($sformatf("dut%0d rst completed", k), cmp[k], 0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    step();

    // Hand-computed anchors for the reference model.
    model(0, 1'b0, b, x, y, c);
    chk("model0 best", b, 0);   chk("model0 mvx", x, 3);  chk("model0 mvy", y, 14);
    chk("model0 cnt", c, 256);
    model(0, 1'b1, b, x, y, c);
    chk("model0ee best", b, 0); chk("model0ee mvx", x, 3); chk("model0ee mvy", y, 14);
    chk("model0ee cnt", c, 108);
    model(1, 1'b0, b, x, y, c);
    chk("model1 best", b, 255); chk("model1 mvx", x, 8); chk("model1 mvy", y, 8);
    chk("model1 cnt", c, 256);
    model(2, 1'b1, b, x, y, c);
    chk("model2 best", b, 5);   chk("model2 mvx", x, 15); chk("model2 mvy", y, 0);
    chk("model2 cnt", c, 256);

    run(0, 1'b0);
    run(1, 1'b1);
    run(2, 1'b0);

    // Restart from DONE: completed drops in the start cycle, first request is at (-8,-8).
    chk("done_before_restart0", cmp[0], 1);
    chk("done_before_restart1", cmp[1], 1);
    load_model(0);
    start = 1'b1;
    #1;
    chk("completed_in_start_cycle0", cmp[0], 0);
    chk("completed_in_start_cycle1", cmp[1], 0);
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d restart busy", k), bsy[k], 1);
      chk($sformatf("dut%0d restart sad_req", k), sreq[k], 1);
      chk($sformatf("dut%0d restart cand_x", k), cx[k], 8);
      chk($sformatf("dut%0d restart cand_y", k), cy[k], 8);
    end

    // Reset during WAIT; the pending sad_done lands one cycle later, in IDLE.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d midrst busy", k), bsy[k], 0);
      chk($sformatf("dut%0d midrst BestDist", k), bd[k], 255);
      chk($sformatf("dut%0d midrst cand_x", k), cx[k], 8);
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d postrst busy", k), bsy[k], 0);
      chk($sformatf("dut%0d postrst completed", k), cmp[k], 0);
      chk($sformatf("dut%0d postrst BestDist", k), bd[k], 255);
      chk($sformatf("dut%0d postrst motionX", k), mx[k], 0);
      chk($sformatf("dut%0d postrst motionY", k), my[k], 0);
    end

    run(0, 1'b0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
